// File: rtl/mem_stage_pkg.sv
// Shared pipeline defines for the memory stage: bus widths, bus layouts and the
// funct3 encodings of the load instructions.
package mem_stage_pkg;

    localparam int XLEN     = 64;
    localparam int EX2MEM_W = 182;
    localparam int MEM2WB_W = 166;
    localparam int MEM2EX_W = 70;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef struct packed {
        logic [6:0]      lsu_op;
        logic [7:0]      data_ram_sel;
        logic            sel_load;
        logic            rf_we;
        logic [4:0]      rf_waddr;
        logic [XLEN-1:0] ex_result;
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } ex2mem_t;

    typedef struct packed {
        logic            rf_we;
        logic [4:0]      rf_waddr;
        logic [XLEN-1:0] rf_wdata;
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } mem2wb_t;

    typedef struct packed {
        logic            rf_we;
        logic [4:0]      rf_waddr;
        logic [XLEN-1:0] rf_wdata;
    } mem2ex_t;

    function automatic logic [2:0] funct3(input logic [31:0] inst);
        return inst[14:12];
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data extraction: shift the addressed field down, then sign/zero-extend
// according to the load type. Purely combinational.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      offset_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] shifted;

    // Right shift zero-fills, so misaligned fields get zero upper bytes for free.
    assign shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        data_o = '0;
        case (funct3_i)
            F3_LB:   data_o = {{56{shifted[7]}},  shifted[7:0]};
            F3_LH:   data_o = {{48{shifted[15]}}, shifted[15:0]};
            F3_LW:   data_o = {{32{shifted[31]}}, shifted[31:0]};
            F3_LD:   data_o = shifted;
            F3_LBU:  data_o = {56'd0, shifted[7:0]};
            F3_LHU:  data_o = {48'd0, shifted[15:0]};
            F3_LWU:  data_o = {32'd0, shifted[31:0]};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: registers the execute bundle, aligns load data from the
// synchronous data RAM, and keeps the RAM word alive across a full-pipe stall.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int EX2MEM_WD = EX2MEM_W,
    parameter int MEM2WB_WD = MEM2WB_W,
    parameter int MEM2EX_WD = MEM2EX_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           stall,
    input  logic [EX2MEM_WD-1:0] ex2mem_bus,
    input  logic [XLEN-1:0]      data_sram_rdata,
    output logic [MEM2WB_WD-1:0] mem2wb_bus,
    output logic [MEM2EX_WD-1:0] mem2ex_fwd
);

    ex2mem_t         stage_q, stage_d;
    logic [XLEN-1:0] hold_q, hold_d;
    logic            hold_valid_q, hold_valid_d;

    ex2mem_t         bus_in;
    logic [XLEN-1:0] load_src;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] rf_wdata;
    mem2wb_t         wb;
    mem2ex_t         fwd;
    logic            stall_mem, stall_wb;

    assign bus_in    = ex2mem_t'(ex2mem_bus);
    assign stall_mem = stall[3];
    assign stall_wb  = stall[4];

    always_comb begin
        stage_d      = stage_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (!stall_mem) begin
            stage_d      = bus_in;
            hold_valid_d = 1'b0;
        end else if (!stall_wb) begin
            stage_d      = '0;
            hold_valid_d = 1'b0;
        end else if (stage_q.sel_load && !hold_valid_q) begin
            // RAM output is only valid for one cycle; latch it before it moves on.
            hold_d       = data_sram_rdata;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            stage_q      <= stage_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    assign load_src = hold_valid_q ? hold_q : data_sram_rdata;

    load_align u_load_align (
        .rdata_i  (load_src),
        .offset_i (stage_q.ex_result[2:0]),
        .funct3_i (funct3(stage_q.inst)),
        .data_o   (load_data)
    );

    assign rf_wdata = stage_q.sel_load ? load_data : stage_q.ex_result;

    always_comb begin
        wb.rf_we     = stage_q.rf_we;
        wb.rf_waddr  = stage_q.rf_waddr;
        wb.rf_wdata  = rf_wdata;
        wb.pc        = stage_q.pc;
        wb.inst      = stage_q.inst;
        fwd.rf_we    = stage_q.rf_we;
        fwd.rf_waddr = stage_q.rf_waddr;
        fwd.rf_wdata = rf_wdata;
    end

    assign mem2wb_bus = wb;
    assign mem2ex_fwd = fwd;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: load-extraction vector table, hand-written stall/reset
// sequences, and a randomized run against a byte-level reference model.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [5:0]   stall;
    logic [181:0] ex2mem_bus;
    logic [63:0]  data_sram_rdata;
    logic [165:0] mem2wb_bus;
    logic [69:0]  mem2ex_fwd;

    int vec_cnt = 0;
    int err_cnt = 0;

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_MEM  = 6'b001000;
    localparam logic [5:0] S_BOTH = 6'b011000;

    mem_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .ex2mem_bus      (ex2mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem2wb_bus      (mem2wb_bus),
        .mem2ex_fwd      (mem2ex_fwd)
    );

    always #5 clk = ~clk;

    // Reference model state: the instruction in the stage and any latched RAM word.
    logic [181:0] m_inst;
    bit           m_lat;
    logic [63:0]  m_latdata;

    function automatic logic [181:0] mk_bus(input logic sel_load, input logic we,
                                            input logic [4:0] waddr, input logic [63:0] exr,
                                            input logic [63:0] pc, input logic [31:0] inst);
        logic [6:0] op;
        logic [7:0] sel;
        op  = 7'($urandom);
        sel = 8'($urandom);
        return {op, sel, sel_load, we, waddr, exr, pc, inst};
    endfunction

    function automatic logic [31:0] ld_inst(input logic [2:0] f3);
        logic [31:0] i;
        i = $urandom;
        i[14:12] = f3;
        return i;
    endfunction

    // Gather n bytes starting at the offset, zero past byte 7, then extend.
    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [2:0] off,
                                             input logic [63:0] rd);
        int n;
        bit sgn;
        logic [63:0] v;
        v = '0;
        case (f3)
            3'd0: begin n = 1; sgn = 1; end
            3'd1: begin n = 2; sgn = 1; end
            3'd2: begin n = 4; sgn = 1; end
            3'd3: begin n = 8; sgn = 0; end
            3'd4: begin n = 1; sgn = 0; end
            3'd5: begin n = 2; sgn = 0; end
            3'd6: begin n = 4; sgn = 0; end
            default: return 64'd0;
        endcase
        for (int i = 0; i < n; i++)
            if (int'(off) + i < 8)
                v |= ((rd >> (8 * (int'(off) + i))) & 64'hFF) << (8 * i);
        if (sgn && v[8*n-1]) v |= ~((64'h1 << (8 * n)) - 64'h1);
        return v;
    endfunction

    function automatic logic [63:0] exp_wdata();
        logic [63:0] src;
        src = m_lat ? m_latdata : data_sram_rdata;
        if (m_inst[166]) return ref_load(m_inst[14:12], m_inst[98:96], src);
        return m_inst[159:96];
    endfunction

    task automatic check(input string name, input logic [165:0] act, input logic [165:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: present inputs, take the edge, update model, present next-cycle
    // RAM data, then compare everything against the model.
    task automatic step(input logic rst, input logic [5:0] st, input logic [181:0] bus,
                        input logic [63:0] rd_next);
        logic [63:0] w;
        rst_n      = rst;
        stall      = st;
        ex2mem_bus = bus;
        @(posedge clk);
        if (!rst) begin
            m_inst = '0; m_lat = 0; m_latdata = '0;
        end else if (!st[3]) begin
            m_inst = bus; m_lat = 0;
        end else if (!st[4]) begin
            m_inst = '0; m_lat = 0;
        end else if (m_inst[166] && !m_lat) begin
            m_lat = 1; m_latdata = data_sram_rdata;
        end
        #1 data_sram_rdata = rd_next;
        #1;
        w = exp_wdata();
        check("mem2wb", mem2wb_bus, {m_inst[165], m_inst[164:160], w, m_inst[95:32], m_inst[31:0]});
        check("mem2ex", {96'd0, mem2ex_fwd}, {96'd0, m_inst[165], m_inst[164:160], w});
        check("hold_valid", {165'd0, dut.hold_valid_q}, {165'd0, m_lat});
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [2:0]  off;
        logic [63:0] rdata;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [63:0] first;
        tbl[0] = '{3'd0, 3'd3, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80};
        tbl[1] = '{3'd6, 3'd4, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321};
        tbl[2] = '{3'd1, 3'd2, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001};
        tbl[3] = '{3'd3, 3'd0, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567};
        tbl[4] = '{3'd5, 3'd6, 64'hFFEE_0000_0000_0000, 64'h0000_0000_0000_FFEE};
        tbl[5] = '{3'd7, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000};
        tbl[6] = '{3'd2, 3'd6, 64'h8899_0000_0000_0000, 64'h0000_0000_0000_8899};
        tbl[7] = '{3'd0, 3'd7, 64'h7F00_0000_0000_0000, 64'h0000_0000_0000_007F};
        tbl[8] = '{3'd3, 3'd4, 64'h1122_3344_5566_7788, 64'h0000_0000_1122_3344};
        tbl[9] = '{3'd4, 3'd1, 64'h0000_0000_0000_F000, 64'h0000_0000_0000_00F0};

        m_inst = '0; m_lat = 0; m_latdata = '0;
        data_sram_rdata = '0;

        // Reset state, with stall asserted to show reset wins.
        step(1'b0, S_BOTH, mk_bus(1, 1, 5'd7, 64'h55, 64'h4, 32'h3), 64'hABCD);
        step(1'b0, S_NONE, mk_bus(1, 1, 5'd7, 64'h55, 64'h4, 32'h3), 64'hABCD);
        check("reset_wb", mem2wb_bus, '0);
        check("reset_fwd", {96'd0, mem2ex_fwd}, '0);

        foreach (tbl[k]) begin
            step(1'b1, S_NONE, mk_bus(1, 1, 5'(k + 1), {61'h1000, tbl[k].off}, 64'h100 + 64'(k),
                                      ld_inst(tbl[k].f3)), tbl[k].rdata);
            check($sformatf("tbl%0d_wdata", k), {102'd0, mem2wb_bus[159:96]}, {102'd0, tbl[k].exp});
        end

        // Non-load result forwarded in the same cycle it is registered.
        step(1'b1, S_NONE, mk_bus(0, 1, 5'd5, 64'h1234, 64'h200, 32'h13), 64'hFFFF);
        check("fwd_nonload", {96'd0, mem2ex_fwd}, {96'd0, 1'b1, 5'd5, 64'h1234});

        // ld under full stall: value must stay the first-cycle RAM word.
        first = 64'hCAFE_F00D_1357_9BDF;
        step(1'b1, S_NONE, mk_bus(1, 1, 5'd9, 64'h800, 64'h300, ld_inst(3'd3)), first);
        for (int c = 0; c < 3; c++) begin
            step(1'b1, S_BOTH, mk_bus(0, 0, 5'd0, 64'h0, 64'h0, 32'h0), {$urandom, $urandom});
            check($sformatf("ld_hold%0d", c), {102'd0, mem2wb_bus[159:96]}, {102'd0, first});
        end

        // Bubble: stall this stage but not writeback.
        step(1'b1, S_MEM, mk_bus(1, 1, 5'd3, 64'h8, 64'h8, 32'h0), 64'h1);
        check("bubble_wb", mem2wb_bus, '0);
        check("bubble_hv", {165'd0, dut.hold_valid_q}, '0);

        // Reset in the middle of a held load.
        step(1'b1, S_NONE, mk_bus(1, 1, 5'd4, 64'h10, 64'h40, ld_inst(3'd2)), 64'h8000_0000_8000_0000);
        step(1'b1, S_BOTH, mk_bus(0, 0, 5'd0, 64'h0, 64'h0, 32'h0), 64'h1111);
        check("pre_rst_hv", {165'd0, dut.hold_valid_q}, {165'd0, 1'b1});
        step(1'b0, S_BOTH, mk_bus(0, 0, 5'd0, 64'h0, 64'h0, 32'h0), 64'h2222);
        check("rst_wb", mem2wb_bus, '0);
        check("rst_hv", {165'd0, dut.hold_valid_q}, '0);

        // Randomized run against the reference model.
        for (int c = 0; c < 400; c++) begin
            logic [5:0] st;
            int r;
            r  = $urandom_range(0, 9);
            st = 6'($urandom);
            if (r < 5)      st[4:3] = 2'b00;
            else if (r < 8) st[4:3] = 2'b11;
            else            st[4:3] = 2'b01;
            step(($urandom_range(0, 49) != 0), st,
                 mk_bus(1'($urandom), 1'($urandom), 5'($urandom), {$urandom, $urandom},
                        {$urandom, $urandom}, $urandom),
                 {$urandom, $urandom});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter EX2MEM_WD, default 182, width of ex2mem_bus.
REQ-002 SHALL have parameter MEM2WB_WD, default 166, width of mem2wb_bus.
REQ-003 SHALL have parameter MEM2EX_WD, default 70, width of mem2ex_fwd.
REQ-004 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port stall  input  6  pipeline stall vector; bit3 = this stage, bit4 = writeback.
REQ-007 SHALL have port ex2mem_bus  input  EX2MEM_WD  {lsu_op[6:0], data_ram_sel[7:0], sel_load, rf_we, rf_waddr[4:0], ex_result[63:0], pc[63:0], inst[31:0]}, MSB first.
REQ-008 SHALL have port data_sram_rdata  input  64  synchronous data RAM read data, valid the cycle after the request.
REQ-009 SHALL have port mem2wb_bus  output  MEM2WB_WD  {rf_we, rf_waddr[4:0], rf_wdata[63:0], pc[63:0], inst[31:0]}.
REQ-010 SHALL have port mem2ex_fwd  output  MEM2EX_WD  {rf_we, rf_waddr[4:0], rf_wdata[63:0]} forwarding to execute.

Function
REQ-011 Stage register SHALL load ex2mem_bus when !stall[3].
REQ-012 Stage register SHALL load all-zero (bubble) when stall[3] & !stall[4].
REQ-013 Stage register SHALL hold when stall[3] & stall[4].
REQ-014 When sel_load=0, rf_wdata SHALL equal ex_result.
REQ-015 When sel_load=1, the load type SHALL be inst[14:12]: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu; 111 yields 0.
REQ-016 Byte offset SHALL be ex_result[2:0]; the selected field SHALL be read data shifted right by 8*offset.
REQ-017 lb/lh/lw SHALL sign-extend the field to 64 bits; lbu/lhu/lwu SHALL zero-extend it; ld SHALL pass all 64 bits.
REQ-018 Misaligned offsets SHALL not be checked; the shifted field SHALL be used with upper bytes zero-filled before extension.
REQ-019 A hold buffer (64-bit data plus a hold_valid flag) SHALL capture data_sram_rdata on the first cycle that stall[3]=1 while the registered instruction has sel_load=1 and hold_valid=0.
REQ-020 While hold_valid=1, load data SHALL come from the hold buffer, not data_sram_rdata.
REQ-021 hold_valid SHALL clear on any cycle with !stall[3], including a cycle that also loads a new instruction.
REQ-022 hold_valid SHALL clear on the cycle the stage register is bubbled.
REQ-023 mem2ex_fwd and the rf_we/rf_waddr/rf_wdata fields of mem2wb_bus SHALL be identical and combinational from the stage register and load data, with zero added latency.
REQ-024 Latency SHALL be one cycle: input accepted at edge N appears on the outputs from edge N until edge N+1.
REQ-025 lsu_op and data_ram_sel SHALL be carried but not affect the result.

Reset
REQ-026 With rst_n=0 at a posedge, the stage register, hold buffer and hold_valid SHALL become 0.
REQ-027 After reset, all outputs SHALL be 0 (rf_we=0) until the first instruction is loaded.
REQ-028 Reset SHALL override stall.

Structure
REQ-029 Bus widths and funct3 load encodings SHALL live in the shared pipeline defines package.
REQ-030 The load extract/extend logic SHALL be one combinational sub-module named load_align.

Verification
REQ-031 Load lb, addr[2:0]=3, rdata=64'h0000_0000_8000_0000 -> rf_wdata=64'hFFFF_FFFF_FFFF_FF80 (byte 3 = 0x80, sign-extended).
REQ-032 Load lwu, addr[2:0]=4, rdata=64'h8765_4321_0000_0000 -> rf_wdata=64'h0000_0000_8765_4321.
REQ-033 Non-load ex_result=64'h1234, rf_we=1, rf_waddr=5 -> mem2ex_fwd={1,5,64'h1234} in the same cycle.
REQ-034 Load ld; stall[3]=stall[4]=1 for 3 cycles; rdata changes to garbage after the first cycle -> rf_wdata stays equal to the first-cycle rdata throughout.
REQ-035 stall[3]=1, stall[4]=0 -> next cycle mem2wb_bus all-zero and hold_valid=0.
REQ-036 rst_n=0 asserted mid-stall with hold_valid=1 -> next cycle all outputs 0 and hold_valid=0.
